// File: rtl/fwd_ctrl.sv
// Hazard and forwarding controller: three-slot scoreboard of in-flight writers
// (E, M, W) driving the D/E operand mux selects and the D-stage stall.
module fwd_ctrl #(
    parameter int REG_AW = 5,
    parameter int TW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] D_rs,
    input  logic [REG_AW-1:0] D_rt,
    input  logic              D_use_rs,
    input  logic              D_use_rt,
    input  logic [TW-1:0]     D_Tuse_rs,
    input  logic [TW-1:0]     D_Tuse_rt,
    input  logic [REG_AW-1:0] D_wa,
    input  logic              D_we,
    input  logic [TW-1:0]     D_Tnew,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        Sel_D_rs,
    output logic [1:0]        Sel_D_rt,
    output logic [1:0]        Sel_E_rs,
    output logic [1:0]        Sel_E_rt
);

    logic              eValid_q, eValid_d;
    logic [REG_AW-1:0] eWa_q, eWa_d;
    logic [TW-1:0]     eTnew_q, eTnew_d;
    logic [REG_AW-1:0] eRs_q, eRs_d;
    logic [REG_AW-1:0] eRt_q, eRt_d;
    logic              eUseRs_q, eUseRs_d;
    logic              eUseRt_q, eUseRt_d;

    logic              mValid_q, mValid_d;
    logic [REG_AW-1:0] mWa_q, mWa_d;
    logic [TW-1:0]     mTnew_q, mTnew_d;

    // W's Tnew is always zero by construction, so it is not stored.
    logic              wValid_q, wValid_d;
    logic [REG_AW-1:0] wWa_q, wWa_d;

    logic liveE, liveM, liveW;
    logic stallRs, stallRt, bubble;

    assign liveE = eValid_q && (eWa_q != '0);
    assign liveM = mValid_q && (mWa_q != '0);
    assign liveW = wValid_q && (wWa_q != '0);

    function automatic logic hazard(input logic [REG_AW-1:0] src, input logic use_,
                                    input logic [TW-1:0] tuse);
        return use_ && ((liveE && (eWa_q == src) && (eTnew_q > tuse)) ||
                        (liveM && (mWa_q == src) && (mTnew_q > tuse)));
    endfunction

    function automatic logic [1:0] selectD(input logic [REG_AW-1:0] src);
        if (liveE && (eWa_q == src) && (eTnew_q == '0))      return 2'b01;
        else if (liveM && (mWa_q == src) && (mTnew_q == '0)) return 2'b10;
        else if (liveW && (wWa_q == src))                     return 2'b11;
        else                                                  return 2'b00;
    endfunction

    function automatic logic [1:0] selectE(input logic [REG_AW-1:0] src, input logic use_);
        if (!use_)                                            return 2'b00;
        else if (liveM && (mWa_q == src) && (mTnew_q == '0)) return 2'b01;
        else if (liveW && (wWa_q == src))                     return 2'b10;
        else                                                  return 2'b00;
    endfunction

    assign stallRs  = hazard(D_rs, D_use_rs, D_Tuse_rs);
    assign stallRt  = hazard(D_rt, D_use_rt, D_Tuse_rt);
    assign stall    = stallRs | stallRt;
    assign bubble   = stall | flush;

    assign Sel_D_rs = selectD(D_rs);
    assign Sel_D_rt = selectD(D_rt);
    assign Sel_E_rs = selectE(eRs_q, eUseRs_q);
    assign Sel_E_rt = selectE(eRt_q, eUseRt_q);

    // M and W always advance; only the entry into E is squashed on stall/flush.
    always_comb begin
        wValid_d = mValid_q;
        wWa_d    = mWa_q;
        mValid_d = eValid_q;
        mWa_d    = eWa_q;
        mTnew_d  = (eTnew_q == '0) ? '0 : eTnew_q - TW'(1);
        eValid_d = D_we && !bubble;
        eWa_d    = D_wa;
        eTnew_d  = D_Tnew;
        eRs_d    = D_rs;
        eRt_d    = D_rt;
        eUseRs_d = D_use_rs && !bubble;
        eUseRt_d = D_use_rt && !bubble;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eValid_q <= 1'b0;
            eWa_q    <= '0;
            eTnew_q  <= '0;
            eRs_q    <= '0;
            eRt_q    <= '0;
            eUseRs_q <= 1'b0;
            eUseRt_q <= 1'b0;
            mValid_q <= 1'b0;
            mWa_q    <= '0;
            mTnew_q  <= '0;
            wValid_q <= 1'b0;
            wWa_q    <= '0;
        end else begin
            eValid_q <= eValid_d;
            eWa_q    <= eWa_d;
            eTnew_q  <= eTnew_d;
            eRs_q    <= eRs_d;
            eRt_q    <= eRt_d;
            eUseRs_q <= eUseRs_d;
            eUseRt_q <= eUseRt_d;
            mValid_q <= mValid_d;
            mWa_q    <= mWa_d;
            mTnew_q  <= mTnew_d;
            wValid_q <= wValid_d;
            wWa_q    <= wWa_d;
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] D_rs, D_rt, D_wa;
    logic       D_use_rs, D_use_rt, D_we, flush;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       stall;
    logic [1:0] Sel_D_rs, Sel_D_rt, Sel_E_rs, Sel_E_rt;

    typedef struct {
        bit [95:0]  name;
        logic [4:0] rs;
        logic       useRs;
        logic [1:0] tuseRs;
        logic [4:0] rt;
        logic       useRt;
        logic [1:0] tuseRt;
        logic [4:0] wa;
        logic       we;
        logic [1:0] tnew;
        logic       flush;
        logic       rstN;
        logic       expStall;
        logic [1:0] expDrs, expDrt, expErs, expErt;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    fwd_ctrl #(.REG_AW(5), .TW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
        .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_wa(D_wa), .D_we(D_we), .D_Tnew(D_Tnew), .flush(flush),
        .stall(stall), .Sel_D_rs(Sel_D_rs), .Sel_D_rt(Sel_D_rt),
        .Sel_E_rs(Sel_E_rs), .Sel_E_rt(Sel_E_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input bit [95:0] nm,
                                input logic [4:0] rs, input logic useRs, input logic [1:0] tuseRs,
                                input logic [4:0] rt, input logic useRt, input logic [1:0] tuseRt,
                                input logic [4:0] wa, input logic we, input logic [1:0] tnew,
                                input logic fl, input logic rstN, input logic eStall,
                                input logic [1:0] eDrs, input logic [1:0] eDrt,
                                input logic [1:0] eErs, input logic [1:0] eErt);
        vec_t v;
        v.name = nm; v.rs = rs; v.useRs = useRs; v.tuseRs = tuseRs;
        v.rt = rt; v.useRt = useRt; v.tuseRt = tuseRt;
        v.wa = wa; v.we = we; v.tnew = tnew; v.flush = fl; v.rstN = rstN;
        v.expStall = eStall; v.expDrs = eDrs; v.expDrt = eDrt;
        v.expErs = eErs; v.expErt = eErt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst_n     = v.rstN;
        D_rs      = v.rs;    D_use_rs = v.useRs; D_Tuse_rs = v.tuseRs;
        D_rt      = v.rt;    D_use_rt = v.useRt; D_Tuse_rt = v.tuseRt;
        D_wa      = v.wa;    D_we     = v.we;    D_Tnew    = v.tnew;
        flush     = v.flush;
        expQ.push_back(v);
    endtask

    task automatic compare(input bit [95:0] nm, input string field,
                           input logic [1:0] actual, input logic [1:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %0s.%0s: got=%b expected=%b at %0t", nm, field, actual, required, $time);
        end
    endtask

    task automatic checkOutput(input vec_t e);
        compare(e.name, "stall",    {1'b0, stall}, {1'b0, e.expStall});
        compare(e.name, "Sel_D_rs", Sel_D_rs, e.expDrs);
        compare(e.name, "Sel_D_rt", Sel_D_rt, e.expDrt);
        compare(e.name, "Sel_E_rs", Sel_E_rs, e.expErs);
        compare(e.name, "Sel_E_rt", Sel_E_rt, e.expErt);
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        rst_n = 1'b0;
        D_rs = '0; D_rt = '0; D_wa = '0;
        D_use_rs = 1'b0; D_use_rt = 1'b0; D_we = 1'b0; flush = 1'b0;
        D_Tuse_rs = '0; D_Tuse_rt = '0; D_Tnew = '0;

        //          name        rs u tu rt u tu wa we tn fl rn  st Drs Drt Ers Ert
        vecs.push_back(mk("idle",     0,0,0, 0,0,0, 0,0,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("popA",     0,0,0, 0,0,0, 3,1,1, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("popB",     0,0,0, 0,0,0, 4,1,0, 0,1, 0,0,0,0,0));
        // Scoreboard holds $4 in E and $3 in M here; async reset must clear both at once.
        vecs.push_back(mk("asyncRst", 4,1,0, 3,1,0, 0,0,0, 0,0, 0,0,0,0,0));
        vecs.push_back(mk("noProd",   8,1,1, 0,0,0, 0,0,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("aluProd",  0,0,0, 0,0,0, 8,1,1, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("aluUse",   8,1,1, 0,0,0, 0,0,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("aluFwdE",  0,0,0, 0,0,0, 0,0,0, 0,1, 0,0,0,1,0));
        vecs.push_back(mk("wFwdD",    8,1,0, 0,0,0, 0,0,0, 0,1, 0,3,0,0,0));
        vecs.push_back(mk("aluGone",  0,0,0, 0,0,0, 0,0,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("ldProd",   0,0,0, 0,0,0, 9,1,2, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("ldUse1",   0,0,0, 9,1,0, 0,0,0, 0,1, 1,0,0,0,0));
        vecs.push_back(mk("ldUse2",   0,0,0, 9,1,0, 0,0,0, 0,1, 1,0,0,0,0));
        vecs.push_back(mk("ldRel",    0,0,0, 9,1,0, 0,0,0, 0,1, 0,0,3,0,0));
        vecs.push_back(mk("ldIdle",   0,0,0, 0,0,0, 0,0,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("ld2Prod",  0,0,0, 0,0,0, 7,1,2, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("ld2Use",   7,1,1, 0,0,0, 0,0,0, 0,1, 1,0,0,0,0));
        vecs.push_back(mk("ld2Rel",   7,1,1, 0,0,0, 0,0,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("ld2FwdE",  0,0,0, 0,0,0, 0,0,0, 0,1, 0,0,0,2,0));
        vecs.push_back(mk("zeroP1",   0,0,0, 0,0,0, 0,1,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("zeroP2",   0,1,0, 0,0,0, 0,1,2, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("zeroP3",   0,1,0, 0,1,0, 0,1,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("zeroAll",  0,1,0, 0,1,0, 0,0,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("p5a",      0,0,0, 0,0,0, 5,1,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("p5b",      5,1,0, 0,0,0, 5,1,0, 0,1, 0,1,0,0,0));
        vecs.push_back(mk("prio",     5,1,0, 5,1,1, 0,0,0, 0,1, 0,1,1,1,0));
        vecs.push_back(mk("prioE",    0,0,0, 0,0,0, 0,0,0, 0,1, 0,0,0,1,1));
        vecs.push_back(mk("p6a",      0,0,0, 0,0,0, 6,1,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("p6b",      0,0,0, 0,0,0, 6,1,1, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("eOverM",   6,1,0, 0,0,0, 0,0,0, 0,1, 1,2,0,0,0));
        vecs.push_back(mk("mFwd",     6,1,0, 0,0,0, 0,0,0, 0,1, 0,2,0,0,0));
        vecs.push_back(mk("flushW",   0,0,0, 0,0,0, 10,1,0, 1,1, 0,0,0,2,0));
        vecs.push_back(mk("flushRd",  10,1,0, 0,0,0, 0,0,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("satProd",  0,0,0, 0,0,0, 12,1,0, 0,1, 0,0,0,0,0));
        vecs.push_back(mk("satE",     12,1,0, 0,0,0, 0,0,0, 0,1, 0,1,0,0,0));
        vecs.push_back(mk("satM",     12,1,0, 12,1,0, 0,0,0, 0,1, 0,2,2,1,0));
        vecs.push_back(mk("satW",     12,1,0, 0,0,0, 0,0,0, 0,1, 0,3,0,2,2));
        vecs.push_back(mk("satGone",  0,0,0, 0,0,0, 0,0,0, 0,1, 0,0,0,0,0));

        repeat (2) @(posedge clk);
        foreach (vecs[i]) applyStimulus(vecs[i]);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

- Hazard and forwarding controller for the five-stage pipeline.
- Keeps a three-slot scoreboard of in-flight register writers (E, M, W) and advances it each cycle.
- From that scoreboard it generates the 2-bit `Sel` codes that drive the 32-bit 4:1 operand muxes in D and E, plus the D-stage stall.
- Sits beside the pipeline registers and produces the select lines those muxes consume.

## Interface

Parameters
- `REG_AW`, default 5: register address width.
- `TW`, default 2: width of the Tuse/Tnew timing fields.

Ports
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset; clears the scoreboard immediately.
- `D_rs`, `D_rt` in REG_AW: source registers of the instruction in D.
- `D_use_rs`, `D_use_rt` in 1: that operand is actually read.
- `D_Tuse_rs`, `D_Tuse_rt` in TW: cycles until the operand is needed; 0 means needed in D.
- `D_wa` in REG_AW: destination register of the instruction in D.
- `D_we` in 1: D instruction writes the register file.
- `D_Tnew` in TW: cycles after entering E until the result exists; 0 means it exists in E.
- `flush` in 1: squash the instruction leaving D; it enters E as a bubble.
- `stall` out 1: freeze PC and the F/D register, insert a bubble into E.
- `Sel_D_rs`, `Sel_D_rt` out 2: select codes for the D-stage operand muxes.
  - 00 = register file, 01 = E result, 10 = M result, 11 = W result.
- `Sel_E_rs`, `Sel_E_rt` out 2: select codes for the E-stage operand muxes.
  - 00 = D/E pipeline value, 01 = M result, 10 = W result, 11 is never driven.

## Operation

Scoreboard contents
- Slots E, M and W each hold `{valid, wa, Tnew}`.
- Slot E additionally holds `{rs, rt, use_rs, use_rt}` for E-stage forwarding.
- A slot is a live producer when `valid && wa != 0`. Register $0 never forwards and never stalls.

Stall computation (combinational, per D operand X in {rs, rt})
- `stall_X = D_use_X && ((liveE && E.wa==D_X && E.Tnew > D_Tuse_X) || (liveM && M.wa==D_X && M.Tnew > D_Tuse_X))`.
- `stall = stall_rs | stall_rt`.

D-stage select (combinational, priority youngest first)
- E match with `E.Tnew==0` → 01.
- Else M match with `M.Tnew==0` → 10.
- Else W match → 11.
- Else 00.
- Drive `Sel_D_*` even when `stall=1`; the mux value is simply discarded.

E-stage select
- Match E.rs/E.rt against M first: M match with `M.Tnew==0` → 01.
- Else W match → 10.
- Else 00.
- An unused operand (`E.use_X=0`) → 00.

Clock edge update
- W ← M. Copy as is; Tnew is forced to 0.
- M ← E, with `Tnew = (E.Tnew==0) ? 0 : E.Tnew-1`. Saturating, never wraps.
- E ← D fields, with `valid = D_we && !stall && !flush`.
  - `use_rs`/`use_rt` are cleared when a bubble is inserted.
- On a stall, M and W still advance; only E receives the bubble.

Reset
- All slots become invalid and all fields zero.
- Outputs then read `stall=0` and every `Sel=00`, independent of the D inputs except through the D fields themselves.
- Reset asserted mid-operation drops in-flight producers on the spot, with no clock needed.

## Timing

Latency
- All outputs are combinational from the current D inputs plus registered scoreboard state; there is no output register.
- A producer entering E at edge n is visible in slot E during cycle n+1, in M during cycle n+2, and in W during cycle n+3. It leaves the scoreboard at edge n+3.

Simultaneous events
- When `stall` and `flush` are both 1, the result is a bubble; the two are equivalent for slot E.
- When E and M both match the same register, E wins. A stall from E's Tnew overrides the forward from M.
- A live producer whose `Tnew > 0` is never selected as a forward source.

Steady-state stall length
- A load (`Tnew=2`) followed by an immediate consumer with `Tuse=1` costs exactly 1 stall cycle.
- The same load followed by a consumer with `Tuse=0` costs exactly 2 stall cycles.

## Test plan

- Reset → assert `rst_n=0` with scoreboard populated, no clock edge → `stall=0`, all `Sel=00`. Release, then drive `D_rs=8` with no producers → `Sel_D_rs=00`.
- ALU back-to-back → issue `D_wa=8, Tnew=1, we=1`, next cycle consumer `D_rs=8, Tuse=1` → `stall=0`. One cycle later the consumer is in E with `Sel_E_rs=01` (from M).
- Load-use → issue `D_wa=9, Tnew=2`, then consumer `D_rt=9, Tuse=0`.
  - `stall=1` for two cycles, then `Sel_D_rt=11` in the release cycle.
  - Slot E shows a bubble during both stall cycles.
- $0 and priority → producers with `wa=0` in E/M/W → no stall, `Sel=00`. Producers with `wa=5, Tnew=0` in both E and M → `Sel_D_rs=01`.
- Flush → issue a writer of $10 with `flush=1` → slot E invalid. A following read of $10 gives `Sel_D_rs=00` and `stall=0`.
- Tnew saturation → producer with `Tnew=0` entering E → M and W Tnew read 0, with no wrap to 3.
